backoff_cnt_gen: RTL and testbench

Backoff counter and contention-window generator for one access category. It consumes the load and enable strobes from the backoff control FSM and produces the 16-bit backoffCnt value that the FSM tests for zero. It tracks the retry stage, so CW doubles on each failure and resets on success or retry limit. It draws a uniform random slot count from a free-running LFSR masked by the current CW.

---
 rtl/backoff_pkg.sv | 32 +++
 rtl/backoff_lfsr.sv | 38 +++
 rtl/backoff_cnt_gen.sv | 84 ++++++++
 tb/tb_backoff_cnt_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backoff_pkg.sv
// ==== backoff_pkg : shared LFSR constants and CW exponent helper (rev 1.0) ====
`default_nettype none

package backoff_pkg;

  localparam logic [15:0] LFSR_POLY          = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT  = 16'hACE1;
  localparam int          CW_EXP_MAX_DEFAULT = 10;

  // exp = min(cwMin+stage, cwMax) when the range is sane, else cwMin; then ceilinged.
  function automatic logic [3:0] cw_exp_calc(
    input logic [3:0] cw_min,
    input logic [3:0] cw_max,
    input logic [3:0] stage
  );
    logic [4:0] sum;
    logic [4:0] e;
    sum = {1'b0, cw_min} + {1'b0, stage};
    if (cw_max >= cw_min) begin
      e = (sum < {1'b0, cw_max}) ? sum : {1'b0, cw_max};
    end else begin
      e = {1'b0, cw_min};
    end
    if (e > 5'(CW_EXP_MAX_DEFAULT)) begin
      e = 5'(CW_EXP_MAX_DEFAULT);
    end
    return e[3:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/backoff_lfsr.sv
// ==== backoff_lfsr : free-running 16-bit Galois LFSR with zero-lock recovery (rev 1.0) ====
`default_nettype none

module backoff_lfsr
  import backoff_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    // An all-zero state would lock up forever, so fall back to the seed.
    if (state_q == 16'h0000) begin
      state_d = SEED;
    end else begin
      state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign lfsr_state = state_q;

endmodule

`default_nettype wire

// File: rtl/backoff_cnt_gen.sv
// ==== backoff_cnt_gen : backoff slot counter and contention-window generator (rev 1.0) ====
`default_nettype none

module backoff_cnt_gen
  import backoff_pkg::*;
#(
  parameter int          CNT_WIDTH  = 16,
  parameter int          CW_EXP_MAX = CW_EXP_MAX_DEFAULT,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic                  macCoreClk,
  input  logic                  macCoreClkHardRst,
  input  logic [3:0]            cwMin,
  input  logic [3:0]            cwMax,
  input  logic                  backoffCntLoad,
  input  logic                  backoffCntEnable,
  input  logic                  tickSlot_p,
  input  logic                  txFailed_p,
  input  logic                  txSuccessful_p,
  input  logic                  retryLTReached_p,
  output logic [CNT_WIDTH-1:0]  backoffCnt,
  output logic [CW_EXP_MAX-1:0] cwCurrent,
  output logic [3:0]            cwStage
);

  logic [15:0]           lfsr_state;
  logic [3:0]            pkg_exp;
  logic [3:0]            cw_exp;
  logic [3:0]            exp_lim;
  logic [4:0]            stage_sum;
  logic [CW_EXP_MAX:0]   pow2;
  logic [CW_EXP_MAX-1:0] cw_mask;
  logic                  stage_can_inc;
  logic [CNT_WIDTH-1:0]  load_val;
  logic                  unused_lfsr_hi;

  backoff_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk        (macCoreClk),
    .rst        (macCoreClkHardRst),
    .lfsr_state (lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[15:CW_EXP_MAX];

  always_comb begin
    pkg_exp       = cw_exp_calc(cwMin, cwMax, cwStage);
    cw_exp        = (pkg_exp > 4'(CW_EXP_MAX)) ? 4'(CW_EXP_MAX) : pkg_exp;
    pow2          = (CW_EXP_MAX + 1)'(1) << cw_exp;
    // At the ceiling the low slice of pow2 is zero and wraps to all ones.
    cw_mask       = pow2[CW_EXP_MAX-1:0] - CW_EXP_MAX'(1);
    stage_sum     = {1'b0, cwMin} + {1'b0, cwStage};
    exp_lim       = (cwMax < 4'(CW_EXP_MAX)) ? cwMax : 4'(CW_EXP_MAX);
    stage_can_inc = (stage_sum < {1'b0, exp_lim}) && (cwStage != 4'hF);
    load_val      = CNT_WIDTH'(lfsr_state[CW_EXP_MAX-1:0] & cw_mask);
  end

  always_ff @(posedge macCoreClk or posedge macCoreClkHardRst) begin
    if (macCoreClkHardRst) begin
      backoffCnt <= '0;
      cwStage    <= 4'd0;
      cwCurrent  <= '0;
    end else begin
      cwCurrent <= cw_mask;

      if (txSuccessful_p || retryLTReached_p) begin
        cwStage <= 4'd0;
      end else if (txFailed_p && stage_can_inc) begin
        cwStage <= cwStage + 4'd1;
      end

      // Load uses this cycle's stage and LFSR, so a coincident failure widens only the next draw.
      if (backoffCntLoad) begin
        backoffCnt <= load_val;
      end else if (backoffCntEnable && tickSlot_p && (backoffCnt != '0)) begin
        backoffCnt <= backoffCnt - CNT_WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_backoff_cnt_gen.sv
// ==== tb_backoff_cnt_gen : randomized bench with behavioural model for backoff_cnt_gen (rev 1.0) ====
`default_nettype none

module tb_backoff_cnt_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cw_min = 4'd4;
  logic [3:0]  cw_max = 4'd10;
  logic        load = 1'b0, en = 1'b0, tick = 1'b0;
  logic        fail = 1'b0, succ = 1'b0, rlt = 1'b0;
  logic [15:0] cnt;
  logic [9:0]  cw;
  logic [3:0]  stage;

  int   total = 0;
  int   bad = 0;
  logic chk_en = 1'b0;
  logic bd_zero = 1'b0;

  logic [15:0] m_cnt, m_lfsr, m_cur;
  logic [3:0]  m_stage;
  logic [9:0]  m_cw;

  always #5 clk = ~clk;

  backoff_cnt_gen dut (
    .macCoreClk        (clk),
    .macCoreClkHardRst (rst),
    .cwMin             (cw_min),
    .cwMax             (cw_max),
    .backoffCntLoad    (load),
    .backoffCntEnable  (en),
    .tickSlot_p        (tick),
    .txFailed_p        (fail),
    .txSuccessful_p    (succ),
    .retryLTReached_p  (rlt),
    .backoffCnt        (cnt),
    .cwCurrent         (cw),
    .cwStage           (stage)
  );

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int exp_of(int st);
    int s;
    int e;
    s = int'(cw_min) + st;
    if (cw_max >= cw_min) e = imin(s, int'(cw_max));
    else e = int'(cw_min);
    return imin(e, 10);
  endfunction

  function automatic int mask_of(int st);
    return (1 << exp_of(st)) - 1;
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    if (s == 16'h0000) return 16'hACE1;
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign m_cur = bd_zero ? 16'h0000 : m_lfsr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 16'd0;
      m_stage <= 4'd0;
      m_cw    <= 10'd0;
      m_lfsr  <= 16'hACE1;
    end else begin
      if (succ || rlt) m_stage <= 4'd0;
      else if (fail && (int'(cw_min) + int'(m_stage)) < imin(int'(cw_max), 10) && m_stage < 4'd15)
        m_stage <= m_stage + 4'd1;
      if (load) m_cnt <= 16'(int'(m_cur) & mask_of(int'(m_stage)));
      else if (en && tick && m_cnt != 16'd0) m_cnt <= m_cnt - 16'd1;
      m_cw   <= 10'(mask_of(int'(m_stage)));
      m_lfsr <= lfsr_next(m_cur);
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("cnt", 32'(cnt), 32'(m_cnt));
      check("stage", 32'(stage), 32'(m_stage));
      check("cw", 32'(cw), 32'(m_cw));
      check("lfsr", 32'(dut.u_lfsr.lfsr_state), 32'(m_lfsr));
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_fail(int n);
    for (int i = 0; i < n; i++) begin
      fail = 1'b1;
      nxt();
    end
    fail = 1'b0;
  endtask

  // Wait until the model LFSR masked by the current CW gives a value in [lo,hi].
  task automatic wait_draw(int lo, int hi, output int v);
    int k;
    v = -1;
    for (k = 0; k < 5000; k++) begin
      v = int'(m_lfsr) & mask_of(int'(m_stage));
      if (v >= lo && v <= hi) break;
      nxt();
    end
    if (k == 5000) check("wait_draw_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick_every8(int n);
    for (int i = 0; i < n; i++) begin
      repeat (7) nxt();
      tick = 1'b1;
      nxt();
      tick = 1'b0;
    end
  endtask

  logic [15:0] seen;
  int v;
  int n_load;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_cw", 32'(cw), 32'd0);
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_lfsr", 32'(dut.u_lfsr.lfsr_state), 32'h0000ACE1);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    nxt();
    check("lfsr_step1", 32'(dut.u_lfsr.lfsr_state), 32'h0000E270);
    nxt();
    check("lfsr_step2", 32'(dut.u_lfsr.lfsr_state), 32'h00007138);

    // reset mid-decrement with count 9
    pulse_fail(2);
    wait_draw(9, 9, v);
    load = 1'b1;
    nxt();
    load = 1'b0;
    check("load9", 32'(cnt), 32'd9);
    en = 1'b1;
    tick = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_cnt", 32'(cnt), 32'd0);
    check("async_stage", 32'(stage), 32'd0);
    check("async_cw", 32'(cw), 32'd0);
    check("async_lfsr", 32'(dut.u_lfsr.lfsr_state), 32'h0000ACE1);
    en = 1'b0;
    tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    nxt();
    check("post_rst_lfsr", 32'(dut.u_lfsr.lfsr_state), 32'h0000E270);

    // 1000 loads at random spacing, CW = 15
    seen = 16'h0;
    for (int i = 0; i < 1000; i++) begin
      n_load = int'($urandom_range(0, 3));
      for (int j = 0; j < n_load; j++) begin
        en = 1'($urandom);
        tick = 1'($urandom);
        nxt();
      end
      load = 1'b1;
      en = 1'($urandom);
      tick = 1'($urandom);
      nxt();
      load = 1'b0;
      if (cnt < 16'd16) seen[cnt[3:0]] = 1'b1;
    end
    en = 1'b0;
    tick = 1'b0;
    check("all16_seen", 32'(seen), 32'h0000FFFF);
    check("cw15", 32'(cw), 32'd15);

    // CW growth and reset on success
    pulse_fail(3);
    nxt();
    check("stage3", 32'(stage), 32'd3);
    check("cw127", 32'(cw), 32'd127);
    pulse_fail(10);
    nxt();
    check("stage6", 32'(stage), 32'd6);
    check("cw1023", 32'(cw), 32'd1023);
    succ = 1'b1;
    nxt();
    succ = 1'b0;
    check("succ_stage0", 32'(stage), 32'd0);
    check("cw_lag", 32'(cw), 32'd1023);
    nxt();
    check("cw_back15", 32'(cw), 32'd15);

    // decrement on slot ticks, freeze while disabled
    wait_draw(3, 15, v);
    load = 1'b1;
    nxt();
    load = 1'b0;
    check("load_n", 32'(cnt), 32'(v));
    en = 1'b1;
    tick_every8(2);
    check("dec2", 32'(cnt), 32'(v - 2));
    en = 1'b0;
    tick_every8(2);
    repeat (4) nxt();
    check("frozen", 32'(cnt), 32'(v - 2));
    en = 1'b1;
    tick_every8(v - 2);
    check("reach0", 32'(cnt), 32'd0);
    tick_every8(3);
    check("hold0", 32'(cnt), 32'd0);

    // coincident events
    wait_draw(1, 15, v);
    load = 1'b1;
    tick = 1'b1;
    nxt();
    load = 1'b0;
    tick = 1'b0;
    check("load_beats_dec", 32'(cnt), 32'(v));
    en = 1'b0;
    pulse_fail(2);
    fail = 1'b1;
    succ = 1'b1;
    nxt();
    fail = 1'b0;
    succ = 1'b0;
    check("clear_beats_fail", 32'(stage), 32'd0);
    v = int'(m_lfsr) & 15;
    load = 1'b1;
    fail = 1'b1;
    nxt();
    load = 1'b0;
    fail = 1'b0;
    check("load_pre_fail", 32'(cnt), 32'(v));
    check("stage_after_fail", 32'(stage), 32'd1);
    rlt = 1'b1;
    nxt();
    rlt = 1'b0;
    check("rlt_clear", 32'(stage), 32'd0);

    // inverted range, then LFSR zero-lock recovery
    cw_max = 4'd3;
    nxt();
    pulse_fail(5);
    nxt();
    check("inv_stage", 32'(stage), 32'd0);
    check("inv_cw", 32'(cw), 32'd15);
    force dut.u_lfsr.state_q = 16'h0000;
    bd_zero = 1'b1;
    #1 release dut.u_lfsr.state_q;
    @(negedge clk);
    bd_zero = 1'b0;
    #1;
    check("zero_reload", 32'(dut.u_lfsr.lfsr_state), 32'h0000ACE1);

    // fully random traffic with changing CW bounds
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        cw_min = 4'($urandom_range(0, 15));
        cw_max = 4'($urandom_range(0, 15));
      end
      load = ($urandom % 8) == 0;
      en   = ($urandom % 4) != 0;
      tick = ($urandom % 3) == 0;
      fail = ($urandom % 5) == 0;
      succ = ($urandom % 30) == 0;
      rlt  = ($urandom % 40) == 0;
      nxt();
    end
    load = 1'b0;
    en = 1'b0;
    tick = 1'b0;
    fail = 1'b0;
    succ = 1'b0;
    rlt = 1'b0;
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
